// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB slave hosting a prescaled down-counting timer with
// periodic / oneshot modes and a level interrupt (INTFLAG & IRQEN).
// Build option: define APB_WAIT_STATE_EN to hold PREADY low for the first
// ACCESS cycle of every transfer (3-cycle transfers). The default build
// completes every transfer with zero wait states.
module apb_timer_slave #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 TIMERINT
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int IW = ADDRWIDTH - 2;
  localparam logic [IW-1:0] IDX_CTRL     = IW'(0);
  localparam logic [IW-1:0] IDX_LOAD     = IW'(1);
  localparam logic [IW-1:0] IDX_VALUE    = IW'(2);
  localparam logic [IW-1:0] IDX_INTSTAT  = IW'(3);
  localparam logic [IW-1:0] IDX_PRESCALE = IW'(4);

  // Access FSM
  logic [1:0] state;
  logic [1:0] state_nxt;

  // Programmer-visible state
  logic                 ctrl_en;
  logic                 ctrl_irqen;
  logic                 ctrl_oneshot;
  logic [DATAWIDTH-1:0] load_q;
  logic [DATAWIDTH-1:0] value_q;
  logic [7:0]           prescale_q;
  logic [7:0]           psc_q;
  logic                 intflag_q;

  // Next-state values
  logic                 en_nxt;
  logic [DATAWIDTH-1:0] value_nxt;
  logic [7:0]           psc_nxt;
  logic                 intflag_nxt;

  // Bus decode
  logic [IW-1:0] word_idx;
  logic sel_ctrl, sel_load, sel_value, sel_intstat, sel_prescale;
  logic addr_hit, intstat_bad, access_err;
  logic access, ready_int, complete;
  logic wr_ok, wr_ctrl, wr_load, wr_value, wr_intstat, wr_prescale;

  // Timer events
  logic tick, tick_eff, zero_hit;

  // Bits [1:0] of the byte address never select anything.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^PADDR[1:0];

  assign word_idx     = PADDR[ADDRWIDTH-1:2];
  assign sel_ctrl     = (word_idx == IDX_CTRL);
  assign sel_load     = (word_idx == IDX_LOAD);
  assign sel_value    = (word_idx == IDX_VALUE);
  assign sel_intstat  = (word_idx == IDX_INTSTAT);
  assign sel_prescale = (word_idx == IDX_PRESCALE);
  assign addr_hit     = sel_ctrl | sel_load | sel_value | sel_intstat | sel_prescale;

  // INTSTAT only accepts bit 0; any other set bit rejects the whole write.
  assign intstat_bad  = sel_intstat && PWRITE && (PWDATA[DATAWIDTH-1:1] != '0);
  assign access_err   = !addr_hit || intstat_bad;

  assign access   = PSEL && PENABLE;
  assign complete = access && ready_int;

`ifdef APB_WAIT_STATE_EN
  logic wait_done;

  assign ready_int = !(access && !wait_done);

  // Marks that the first ACCESS cycle has elapsed; cleared as the transfer completes.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) wait_done <= 1'b0;
    else        wait_done <= access && !wait_done;
  end
`else
  assign ready_int = 1'b1;
`endif

  assign PREADY  = PRESET | ready_int;
  assign PSLVERR = !PRESET && complete && access_err;

  assign wr_ok       = complete && PWRITE && !access_err;
  assign wr_ctrl     = wr_ok && sel_ctrl;
  assign wr_load     = wr_ok && sel_load;
  assign wr_value    = wr_ok && sel_value;
  assign wr_intstat  = wr_ok && sel_intstat;
  assign wr_prescale = wr_ok && sel_prescale;

  // Tracks the APB phase; a reset abandons whatever transfer was in flight.
  always_ff @(posedge PCLK or posedge PRESET) begin
    // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
    if (PRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode for the access FSM.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:   state_nxt = (PSEL && !PENABLE) ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (!ready_int) state_nxt = ST_ACCESS;
        else if (PSEL)  state_nxt = ST_SETUP;
        else            state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A VALUE write overrides the tick completely, so it never races the counter.
  assign tick     = ctrl_en && (psc_q == prescale_q);
  assign tick_eff = tick && !wr_value;
  assign zero_hit = tick_eff && (value_q == '0);

  // Timer next state: tick effects first, then APB writes take precedence.
  always_comb begin
    en_nxt      = ctrl_en;
    value_nxt   = value_q;
    intflag_nxt = intflag_q;

    if (tick_eff) begin
      if (value_q != '0)     value_nxt = value_q - DATAWIDTH'(1);
      else if (ctrl_oneshot) en_nxt    = 1'b0;
      else                   value_nxt = load_q;
    end
    if (wr_ctrl)  en_nxt    = PWDATA[0];
    if (wr_value) value_nxt = PWDATA;

    // Setting the flag beats a simultaneous write-1-to-clear.
    if (zero_hit)                     intflag_nxt = 1'b1;
    else if (wr_intstat && PWDATA[0]) intflag_nxt = 1'b0;

    // Prescaler restarts whenever it is idle, wraps, VALUE is rewritten or EN toggles.
    if (!ctrl_en || tick || wr_value || (en_nxt != ctrl_en)) psc_nxt = 8'd0;
    else                                                     psc_nxt = psc_q + 8'd1;
  end

  // Timer and register state.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_en      <= 1'b0;
      ctrl_irqen   <= 1'b0;
      ctrl_oneshot <= 1'b0;
      load_q       <= '0;
      value_q      <= '0;
      prescale_q   <= 8'd0;
      psc_q        <= 8'd0;
      intflag_q    <= 1'b0;
    end else begin
      ctrl_en   <= en_nxt;
      value_q   <= value_nxt;
      psc_q     <= psc_nxt;
      intflag_q <= intflag_nxt;
      if (wr_ctrl) begin
        ctrl_irqen   <= PWDATA[1];
        ctrl_oneshot <= PWDATA[2];
      end
      if (wr_load)     load_q     <= PWDATA;
      if (wr_prescale) prescale_q <= PWDATA[7:0];
    end
  end

  // Read mux: only driven during a read access phase, zero otherwise.
  always_comb begin
    PRDATA = '0;
    if (!PRESET && access && !PWRITE) begin
      if (sel_ctrl)     PRDATA = DATAWIDTH'({ctrl_oneshot, ctrl_irqen, ctrl_en});
      if (sel_load)     PRDATA = load_q;
      if (sel_value)    PRDATA = value_q;
      if (sel_intstat)  PRDATA = DATAWIDTH'(intflag_q);
      if (sel_prescale) PRDATA = DATAWIDTH'(prescale_q);
    end
  end

  assign TIMERINT = intflag_q && ctrl_irqen;

endmodule
